fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Fetch-side consumer of the hazard unit's StallF/StallD/FlushD/PCSrcE signals in the 6-stage core.
- Owns the PC register and drives requests to a synchronous instruction memory with 1-cycle read latency.
- Captures in-flight instructions in a skid buffer while decode is stalled, so no fetch is lost or duplicated.
- Applies execute-stage redirects, discarding stale fetches, and delivers the IF/ID register (InstrD, PCD, PCPlus4D, ValidD).

Parameters:
- XLEN, 32, PC/instruction width.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- BUF_DEPTH, 2, skid buffer entries (power of 2, >=2).
- NOP, 32'h0000_0013, instruction presented on a bubble.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallF  in  1  hold PC, issue no new request.
- StallD  in  1  hold IF/ID outputs.
- FlushD  in  1  load bubble into IF/ID.
- PCSrcE  in  2  00 sequential, 01 branch/jal (PCTargetE), 10 jalr (ALUResultE), 11 treated as 00.
- PCTargetE  in  XLEN  branch/jal target.
- ALUResultE  in  XLEN  jalr target.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  read address (= PCF).
- imem_rdata  in  32  data for the request issued the previous cycle.
- PCF  out  XLEN  current fetch PC.
- InstrD  out  32  decode instruction.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4, mod 2^XLEN.
- ValidD  out  1  InstrD is a real instruction.

Behaviour:
- Reset (async, while rst=1):
  - PCF=RESET_PC; buffer count=0; inflight=0.
  - InstrD=NOP, PCD=0, PCPlus4D=4, ValidD=0, imem_req=0.
- State:
  - inflight flag plus inflight PC, meaning a response arrives next cycle.
  - Circular skid buffer of {instr, pc}, with head, tail and count.
- Issue:
  - imem_req = !rst && !StallF && redirect==0 && (count+inflight) < BUF_DEPTH.
  - imem_addr=PCF combinationally.
  - On issue: PCF<=PCF+4 (wraps mod 2^XLEN); inflight<=1 with pc=PCF; else inflight<=0.
- Response routing (inflight=1 in a cycle):
  - If IF/ID loads this cycle and count==0, it goes straight to IF/ID.
  - Otherwise it is pushed to the buffer tail.
- IF/ID update, in priority order:
  1. FlushD or redirect: InstrD=NOP, ValidD=0. Overrides StallD.
  2. StallD: hold all outputs.
  3. Buffer non-empty: pop head.
  4. Response present: load it.
  5. Otherwise: bubble (NOP, ValidD=0, PCD/PCPlus4D hold).
- Simultaneous push and pop keeps count unchanged.
- Push with count==BUF_DEPTH cannot occur, because the issue rule guarantees space. Verification flags it as an assertion error.
- Redirect (PCSrcE==01 or 10):
  - Highest priority, overrides StallF.
  - PCF<=target with bits[1:0] forced to 0. The jalr target also has bit0 cleared.
  - Buffer cleared (count=0, head=tail).
  - A response returning in the redirect cycle is dropped.
  - inflight<=0; no request issues in the redirect cycle.
  - The first request at the target issues the next cycle, unless StallF is asserted.
- Throughput: 1 instruction/cycle in steady state (count=0, inflight=1 every cycle).
- Latency: 2 cycles from reset release to first ValidD=1 (issue at cycle 1, IF/ID loaded end of cycle 2).
- StallF=1 with StallD=0: the buffer and inflight response drain into IF/ID, then bubbles follow.
- StallD=1 with StallF=0: issuing continues until count+inflight reaches BUF_DEPTH, then imem_req=0.
- Reset asserted mid-operation: all state returns to reset values immediately. Pending responses are ignored.

Test Plan:
1. Release reset, no stalls, imem returns addr-tagged data → imem_addr 0,4,8,…; InstrD of word at PC 0 appears 2 cycles after reset with ValidD=1; one instruction per cycle thereafter.
2. StallD=1 for 3 cycles mid-stream (StallF=1 too) → outputs held; the in-flight word at PC 0x10 is captured in the buffer; after release, PCD sequence continues 0x10,0x14 with no gap, duplicate or skip.
3. StallD=1, StallF=0 for 4 cycles → imem_req drops after 2 issues (count=2); on release, buffered entries pop in order, then the stream resumes.
4. PCSrcE=01, PCTargetE=0x200 while a response is in flight and the buffer holds 1 entry → ValidD=0 next cycle; imem_addr=0x200 the following cycle; no stale instruction ever reaches ValidD=1.
5. PCSrcE=10, ALUResultE=0x103, with StallF=1 the same cycle → PCF=0x100 (low bits cleared); the redirect is taken despite StallF.
6. rst pulsed asynchronously between clock edges mid-stream → outputs return to reset values immediately; a response arriving after release is not delivered.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_unit
//
// Fetch stage of the 6-stage core. It owns the fetch PC and issues requests to
// a synchronous instruction memory with one cycle of read latency. It delivers
// the IF/ID pipeline register to decode.
//
// Words that come back while decode is stalled are parked in a small circular
// skid buffer. No fetch is lost or duplicated across stalls. The issue rule
// never lets buffered words plus the outstanding request exceed the buffer
// depth, so a returning word always has a slot.
//
// An execute-stage redirect (PCSrcE = 01/10) has the highest priority, above
// StallF. The redirect cycle does the following:
//   - loads the aligned target into the PC,
//   - clears the buffer,
//   - drops the word returning in that cycle,
//   - puts a bubble into IF/ID.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   StallF              hold PC, issue no new request
//   StallD              hold IF/ID outputs
//   FlushD              load a bubble into IF/ID
//   PCSrcE[1:0]         00 seq, 01 branch/jal (PCTargetE), 10 jalr
//                       (ALUResultE), 11 treated as seq
//   PCTargetE, ALUResultE  redirect targets
//   imem_req/imem_addr  read request and address (address == PCF)
//   imem_rdata          word for the request issued the previous cycle
//   PCF                 current fetch PC
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000,
  parameter int unsigned       BUF_DEPTH = 2,
  parameter logic [31:0]       NOP       = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int unsigned    PTR_W   = $clog2(BUF_DEPTH);
  // One extra bit so the count can represent "full" and count+inflight.
  localparam int unsigned    CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [XLEN-1:0]  FOUR    = XLEN'(4);
  localparam logic [XLEN-1:0]  ALIGN_M = ~XLEN'(3);

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_src_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  pcf_q;
  logic             inflight_q;
  logic [XLEN-1:0]  inflight_pc_q;

  entry_t           buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0]      instr_d_q;
  logic [XLEN-1:0]  pcd_q;
  logic [XLEN-1:0]  pcplus4d_q;
  logic             validd_q;

  // ---------------------------------------------------------------------------
  // Redirect decode
  // ---------------------------------------------------------------------------
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    case (pc_src_e'(PCSrcE))
      PC_BRANCH: begin
        redirect    = 1'b1;
        redirect_pc = PCTargetE & ALIGN_M;
      end
      // Clearing bits[1:0] also covers the jalr rule that clears bit0.
      PC_JALR: begin
        redirect    = 1'b1;
        redirect_pc = ALUResultE & ALIGN_M;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue and data-path control
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] occupancy;
  logic             issue;
  logic             buf_empty;
  logic             ifid_load;   // IF/ID takes a real word (buffer or memory)
  logic             pop;
  logic             bypass;      // returning word goes straight to IF/ID
  logic             push;

  // Buffered words plus the outstanding request must never exceed the depth.
  // Otherwise a returning word could find the buffer full.
  assign occupancy = count_q + CNT_W'(inflight_q);
  assign issue     = !StallF && !redirect && (occupancy < DEPTH_C);
  assign imem_req  = !rst && issue;
  assign imem_addr = pcf_q;

  assign buf_empty = (count_q == '0);
  assign ifid_load = !redirect && !FlushD && !StallD;
  assign pop       = ifid_load && !buf_empty;
  assign bypass    = ifid_load && buf_empty && inflight_q;
  // A word returning during a redirect belongs to the wrong path and is dropped.
  assign push      = inflight_q && !redirect && !bypass;

  // ---------------------------------------------------------------------------
  // PC and in-flight tracking
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only. Every
  // register then samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      if (redirect) begin
        pcf_q <= redirect_pc;
      end else if (issue) begin
        pcf_q <= pcf_q + FOUR;
      end
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pcf_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  // NOTE: the entry storage has no reset. An entry is only read after a push
  // has written it, because head/tail/count are reset. This keeps the array a
  // plain memory.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[tail_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;  // a push and a pop together leave the count unchanged
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d_q  <= NOP;
      pcd_q      <= '0;
      pcplus4d_q <= FOUR;
      validd_q   <= 1'b0;
    end else if (redirect || FlushD) begin
      // A flush wins over a decode stall.
      instr_d_q <= NOP;
      validd_q  <= 1'b0;
    end else if (StallD) begin
      // hold
    end else if (!buf_empty) begin
      // Older buffered words go first, so order is preserved.
      instr_d_q  <= buf_q[head_q].instr;
      pcd_q      <= buf_q[head_q].pc;
      pcplus4d_q <= buf_q[head_q].pc + FOUR;
      validd_q   <= 1'b1;
    end else if (inflight_q) begin
      instr_d_q  <= imem_rdata;
      pcd_q      <= inflight_pc_q;
      pcplus4d_q <= inflight_pc_q + FOUR;
      validd_q   <= 1'b1;
    end else begin
      // Nothing to deliver: bubble, PC fields keep their last value.
      instr_d_q <= NOP;
      validd_q  <= 1'b0;
    end
  end

  assign PCF      = pcf_q;
  assign InstrD   = instr_d_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcplus4d_q;
  assign ValidD   = validd_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Directed bench for fetch_unit. A behavioural instruction memory returns an
// address-tagged word one cycle after each request. Registered outputs are
// checked 1 ns after the rising edge. Combinational request outputs are checked
// 1 ns after the inputs change.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2), .NOP(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // Synchronous instruction memory, one-cycle latency; junk when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? tag(imem_addr) : 32'hDEAD_BEEF;
  end

  // A push into a full buffer must never happen.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(dut.push && dut.count_q == 2'd2)) else begin
        n_total++;
        $error("FAIL buf_overflow: observed push with count %0d required no push", dut.count_q);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h required 0x%08h", name, obs, exp);
  endtask

  task automatic check_ifid(input string name, input logic [31:0] pc);
    check({name, ".ValidD"},   {31'd0, ValidD}, 32'd1);
    check({name, ".PCD"},      PCD,             pc);
    check({name, ".PCPlus4D"}, PCPlus4D,        pc + 32'd4);
    check({name, ".InstrD"},   InstrD,          tag(pc));
  endtask

  task automatic check_reset(input string name);
    check({name, ".PCF"},      PCF,               32'h0);
    check({name, ".InstrD"},   InstrD,            NOP);
    check({name, ".PCD"},      PCD,               32'h0);
    check({name, ".PCPlus4D"}, PCPlus4D,          32'h4);
    check({name, ".ValidD"},   {31'd0, ValidD},   32'd0);
    check({name, ".imem_req"}, {31'd0, imem_req}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 2'b00; PCTargetE = '0; ALUResultE = '0;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #2;
    check_reset("reset");

    // ---- 1: stream from reset ----
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("c1.req",  {31'd0, imem_req}, 32'd1);
    check("c1.addr", imem_addr, 32'h0);
    tick();  // E1
    check("c2.ValidD", {31'd0, ValidD}, 32'd0);
    check("c2.addr",   imem_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      tick();  // E2..E5
      check_ifid("stream", 32'(4 * k));
      check("stream.addr", imem_addr, 32'(4 * (k + 2)));
    end

    // ---- 2: StallD+StallF for 3 cycles, word at 0x10 in flight ----
    StallD = 1'b1; StallF = 1'b1;
    #1;
    check("stall2.req", {31'd0, imem_req}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_ifid("stall2.hold", 32'h0C);
      check("stall2.req_held", {31'd0, imem_req}, 32'd0);
    end
    StallD = 1'b0; StallF = 1'b0;
    #1;
    check("stall2.resume_addr", imem_addr, 32'h14);
    tick(); check_ifid("stall2.pc10", 32'h10);
    tick(); check_ifid("stall2.pc14", 32'h14);
    tick(); check_ifid("stall2.pc18", 32'h18);

    // ---- 3: StallD only for 4 cycles ----
    StallD = 1'b1;
    #1;
    check("stall3.req0", {31'd0, imem_req}, 32'd1);
    check("stall3.addr0", imem_addr, 32'h20);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_ifid("stall3.hold", 32'h18);
      check("stall3.req_off", {31'd0, imem_req}, 32'd0);
    end
    StallD = 1'b0;
    #1;
    check("stall3.full_req", {31'd0, imem_req}, 32'd0);
    tick(); check_ifid("stall3.pop1c", 32'h1C);
    check("stall3.addr24", imem_addr, 32'h24);
    tick(); check_ifid("stall3.pop20", 32'h20);
    check("stall3.addr28", imem_addr, 32'h28);
    tick(); check_ifid("stall3.pc24", 32'h24);

    // ---- 4: branch redirect with buffer=1 and a word in flight ----
    StallD = 1'b1;
    tick();
    check_ifid("br.prep", 32'h24);
    StallD = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h200;
    #1;
    check("br.req_redirect", {31'd0, imem_req}, 32'd0);
    tick();
    PCSrcE = 2'b00;
    check("br.ValidD0", {31'd0, ValidD}, 32'd0);
    check("br.InstrD",  InstrD, NOP);
    check("br.PCF",     PCF, 32'h200);
    #1;
    check("br.req", {31'd0, imem_req}, 32'd1);
    check("br.addr", imem_addr, 32'h200);
    tick();
    check("br.ValidD1", {31'd0, ValidD}, 32'd0);
    check("br.PCD_hold", PCD, 32'h24);
    tick();
    check_ifid("br.target", 32'h200);

    // ---- 5: jalr redirect overriding StallF, target low bits cleared ----
    PCSrcE = 2'b10; ALUResultE = 32'h103; StallF = 1'b1;
    #1;
    check("jalr.req", {31'd0, imem_req}, 32'd0);
    tick();
    PCSrcE = 2'b00; StallF = 1'b0;
    check("jalr.PCF", PCF, 32'h100);
    check("jalr.ValidD0", {31'd0, ValidD}, 32'd0);
    tick();
    check("jalr.ValidD1", {31'd0, ValidD}, 32'd0);
    tick();
    check_ifid("jalr.target", 32'h100);

    // ---- 6: asynchronous reset pulse between edges ----
    #3;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    rst = 1'b0;
    #1;
    check("rst6.addr", imem_addr, 32'h0);
    check("rst6.req", {31'd0, imem_req}, 32'd1);
    tick();
    check("rst6.no_stale", {31'd0, ValidD}, 32'd0);
    check("rst6.PCF", PCF, 32'h4);
    tick();
    check_ifid("rst6.first", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
